// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: widths, op codes and the
// issue/result records that travel down its two-stage pipeline.
package alu_arb_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SH_W     = $clog2(DATA_W);

  typedef logic req_id_t;

  // 1110/1111 are the signed add/sub; they are the only ops that flag overflow.
  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_NOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_ADDU = 4'b1001,
    OP_SUBU = 4'b1010,
    OP_PASA = 4'b1011,
    OP_PASB = 4'b1100,
    OP_ANDN = 4'b1101,
    OP_ADD  = 4'b1110,
    OP_SUB  = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
    req_id_t           id;
  } issue_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              zero;
    logic              less;
    logic              overflow;
    req_id_t           id;
  } result_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; less is always the signed a<b compare, overflow
// is raised only by the signed add/sub op codes.
module alu_arbiter_alu
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_res,
  output logic              o_zero,
  output logic              o_less,
  output logic              o_overflow
);

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [SH_W-1:0]   w_sh;
  logic              w_add_ovf;
  logic              w_sub_ovf;

  assign w_sum     = i_a + i_b;
  assign w_diff    = i_a - i_b;
  assign w_sh      = i_b[SH_W-1:0];
  assign w_add_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
  assign w_sub_ovf = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_diff[DATA_W-1] != i_a[DATA_W-1]);
  assign o_less    = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_res      = '0;
    o_overflow = 1'b0;
    case (i_op)
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_NOR:  o_res = ~(i_a | i_b);
      OP_SLL:  o_res = i_a << w_sh;
      OP_SRL:  o_res = i_a >> w_sh;
      OP_SRA:  o_res = $signed(i_a) >>> w_sh;
      OP_SLT:  o_res = {{(DATA_W-1){1'b0}}, o_less};
      OP_SLTU: o_res = {{(DATA_W-1){1'b0}}, (i_a < i_b)};
      OP_ADDU: o_res = w_sum;
      OP_SUBU: o_res = w_diff;
      OP_PASA: o_res = i_a;
      OP_PASB: o_res = i_b;
      OP_ANDN: o_res = i_a & ~i_b;
      OP_ADD: begin
        o_res      = w_sum;
        o_overflow = w_add_ovf;
      end
      OP_SUB: begin
        o_res      = w_diff;
        o_overflow = w_sub_ovf;
      end
      default: o_res = '0;
    endcase
  end

  assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: round-robin grant into an issue register, ALU,
// then a result register. Define ALU_ARB_FIXED_PRIO_EN for fixed r0 priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [DATA_W-1:0]   r0_a,
  input  logic [DATA_W-1:0]   r0_b,
  input  logic [ALU_OP_W-1:0] r0_op,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [DATA_W-1:0]   r1_a,
  input  logic [DATA_W-1:0]   r1_b,
  input  logic [ALU_OP_W-1:0] r1_op,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_id,
  output logic [DATA_W-1:0]   res_data,
  output logic                res_zero,
  output logic                res_less,
  output logic                res_overflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Requesters hold valid and payload until accepted; rk_ready is combinational
  // from the request valids and pipeline occupancy, and is low during reset.

  logic [N_REQ-1:0]  w_req;
  issue_t            r_is;
  logic              r_is_valid;
  result_t           r_rs;
  logic              r_res_valid;
  logic              w_is_adv;
  logic              w_is_free;
  logic              w_accept;
  req_id_t           w_grant;
  issue_t            w_is_next;
  result_t           w_rs_next;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_zero;
  logic              w_alu_less;
  logic              w_alu_ovf;

  assign w_req     = {r1_valid, r0_valid};
  assign w_is_adv  = r_is_valid && (!r_res_valid || res_ready);
  assign w_is_free = !r_is_valid || w_is_adv;
  assign w_accept  = !rst && w_is_free && (|w_req);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant = w_req[0] ? 1'b0 : 1'b1;
`else
  req_id_t r_last;

  // Contention goes to whoever did not win last; reset makes r0 win first.
  assign w_grant = (&w_req) ? ~r_last : w_req[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant;
    end
  end
`endif

  assign r0_ready = w_accept && (w_grant == 1'b0);
  assign r1_ready = w_accept && (w_grant == 1'b1);

  always_comb begin
    w_is_next    = '0;
    w_is_next.id = w_grant;
    if (w_grant) begin
      w_is_next.a  = r1_a;
      w_is_next.b  = r1_b;
      w_is_next.op = alu_op_e'(r1_op);
    end else begin
      w_is_next.a  = r0_a;
      w_is_next.b  = r0_b;
      w_is_next.op = alu_op_e'(r0_op);
    end
  end

  alu_arbiter_alu u_alu (
    .i_a        (r_is.a),
    .i_b        (r_is.b),
    .i_op       (r_is.op),
    .o_res      (w_alu_res),
    .o_zero     (w_alu_zero),
    .o_less     (w_alu_less),
    .o_overflow (w_alu_ovf)
  );

  assign w_rs_next = '{data: w_alu_res, zero: w_alu_zero, less: w_alu_less,
                       overflow: w_alu_ovf, id: r_is.id};

  // Drain, advance and accept may all happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is        <= '0;
      r_is_valid  <= 1'b0;
      r_rs        <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is       <= w_is_next;
        r_is_valid <= 1'b1;
      end else if (w_is_adv) begin
        r_is_valid <= 1'b0;
      end
      if (w_is_adv) begin
        r_rs        <= w_rs_next;
        r_res_valid <= 1'b1;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid    = r_res_valid;
  assign res_id       = r_rs.id;
  assign res_data     = r_rs.data;
  assign res_zero     = r_rs.zero;
  assign res_less     = r_rs.less;
  assign res_overflow = r_rs.overflow;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (fixed at 2 in this revision).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports r0_valid/r1_valid  input  1  requester k presents an operation.
REQ-005 SHALL have ports r0_ready/r1_ready  output  1  requester k operation accepted this cycle (valid&ready).
REQ-006 SHALL have ports r0_a, r0_b, r1_a, r1_b  input  32  operands; r0_op, r1_op  input  4  ALU op code.
REQ-007 SHALL have port res_valid  output  1  result register holds a result.
REQ-008 SHALL have port res_ready  input  1  consumer takes result (valid&ready).
REQ-009 SHALL have ports res_id  output  1  originating requester; res_data  output  32  ALU result.
REQ-010 SHALL have ports res_zero, res_less, res_overflow  output  1  ALU flags captured with res_data.

Function
REQ-011 SHALL be a 2-stage pipeline: issue register (IS: a, b, op, id, is_valid) then result register (RS: data, flags, id, res_valid).
REQ-012 SHALL drive the internal ALU only from IS contents; ALU is combinational, RS captures its outputs.
REQ-013 SHALL advance IS->RS when is_valid and (!res_valid or res_ready); IS empties unless refilled same cycle.
REQ-014 SHALL accept a new request into IS when !is_valid or IS advances this cycle; rk_ready high only for the granted requester under that condition.
REQ-015 SHALL grant round-robin: if both valid, grant the requester not granted last; if one valid, grant it; pointer updates only on an accepted transfer.
REQ-016 SHALL assert at most one rk_ready per cycle; rk_ready SHALL not depend on res_ready of the opposite requester only.
REQ-017 SHALL give latency of exactly 2 cycles from accept to res_valid with no backpressure; sustained throughput 1 op/cycle.
REQ-018 SHALL hold RS stable (data, flags, id) while res_valid and !res_ready.
REQ-019 SHALL, when RS full and stalled and IS full, deassert both rk_ready (full condition), without losing either entry.
REQ-020 SHALL, on simultaneous RS drain and IS advance and new accept, complete all three in the same cycle.
REQ-021 SHALL pass res_overflow exactly as the ALU computes it (asserted only for signed add/sub op codes).

Reset
REQ-022 SHALL on rst clear is_valid, res_valid, r0_ready, r1_ready; res_data=0, flags=0, res_id=0.
REQ-023 SHALL on rst set the round-robin pointer so requester 0 wins the first contended grant.
REQ-024 SHALL, on rst mid-operation, discard in-flight IS/RS contents; no result is emitted for them.

Configuration
REQ-025 SHALL honour macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins contention, pointer logic removed; undefined -> round-robin per REQ-015.

Structure
REQ-026 SHALL place in shared package alu_arb_pkg: ALU op width constant (4), data width constant (32), requester id type, issue/result record typedefs.
REQ-027 SHALL instantiate the existing ALU module as its single sub-module; arbitration and pipeline control stay in alu_arbiter.

Verification
REQ-028 Single add: r0 a=0x00000003 b=0x00000004 op=4'b1110 -> 2 cycles later res_valid=1, res_data=0x00000007, res_id=0, res_zero=0.
REQ-029 Overflow: r1 a=0x7FFFFFFF b=0x00000001 op=4'b1110 -> res_data=0x80000000, res_overflow=1, res_id=1; sub a=5 b=5 op=4'b1111 -> res_data=0, res_zero=1.
REQ-030 Contention: r0 and r1 valid 4 consecutive cycles -> grants alternate 0,1,0,1 (0,0,0,0 with ALU_ARB_FIXED_PRIO_EN); res_id sequence matches.
REQ-031 Backpressure: res_ready=0 for 5 cycles with requests pending -> exactly 2 accepts then r0_ready=r1_ready=0; RS held constant; on res_ready=1 results drain in order, none lost or duplicated.
REQ-032 Reset mid-flight: rst asserted 1 cycle with IS and RS full -> next cycle res_valid=0, no stale result ever appears; first contended grant goes to r0.
